// File: rtl/sha3_pkg.sv
// Shared constants for the SHA-3 datapath: lane width and default lane FIFO depth.
package sha3_pkg;
  localparam int LANE_W     = 64;
  localparam int FIFO_DEPTH = 16;
endpackage

// File: rtl/sync_lane_fifo_ram.sv
// Simple dual-port lane storage: synchronous write, synchronous read with enable,
// registered read data. The array itself is never reset.
module sync_lane_fifo_ram #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Only the read register is cleared, so the visible head word reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_lane_fifo.sv
// First-word-fall-through lane FIFO: pointer/level control around a registered-read RAM,
// with a one-word bypass register that keeps one-word-per-cycle streaming at level 1.
module sync_lane_fifo
  import sha3_pkg::*;
#(
  parameter int WIDTH    = LANE_W,
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int AFULL_TH = DEPTH - 2,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W:0]   level,
  output logic              almost_full
);

  localparam logic [ADDR_W:0] LEVEL_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LEVEL_AF  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] LEVEL_ONE = (ADDR_W+1)'(1);

  logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [ADDR_W:0]   level_d, level_q;
  logic              out_valid_d, out_valid_q;
  logic              byp_sel_d, byp_sel_q;
  logic [WIDTH-1:0]  byp_data_d, byp_data_q;

  logic              push, pop, bypass, load_ram;
  logic              wr_en, rd_en;
  logic [ADDR_W:0]   ram_cnt;
  logic [WIDTH-1:0]  ram_rd_data;

  assign in_ready    = (level_q < LEVEL_MAX);
  assign out_valid   = out_valid_q;
  assign level       = level_q;
  assign almost_full = (level_q >= LEVEL_AF);
  assign out_data    = byp_sel_q ? byp_data_q : ram_rd_data;

  // Words already written to the RAM but not yet moved to the head position.
  assign ram_cnt  = level_q - (ADDR_W+1)'(out_valid_q);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid_q && out_ready;
  assign load_ram = (ram_cnt != '0) && (!out_valid_q || pop);
  // Refill the head straight from in_data when it is being popped and the RAM is empty.
  assign bypass   = push && pop && (ram_cnt == '0);
  assign wr_en    = push && !clr;
  assign rd_en    = load_ram && !clr;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    byp_sel_d   = byp_sel_q;
    byp_data_d  = byp_data_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (load_ram || bypass) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        level_d = level_q + LEVEL_ONE;
      end else if (pop && !push) begin
        level_d = level_q - LEVEL_ONE;
      end
      out_valid_d = load_ram || bypass || (out_valid_q && !pop);
      if (bypass) begin
        byp_sel_d  = 1'b1;
        byp_data_d = in_data;
      end else if (load_ram) begin
        byp_sel_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      byp_sel_q   <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      byp_sel_q   <= byp_sel_d;
      byp_data_q  <= byp_data_d;
    end
  end

  sync_lane_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr_q),
    .wr_data(in_data),
    .rd_en  (rd_en),
    .rd_addr(rd_ptr_q),
    .rd_data(ram_rd_data)
  );

endmodule

// File: tb/tb_sync_lane_fifo.sv
// Scoreboard bench for sync_lane_fifo: accepted words are queued, popped words compared.
module tb_sync_lane_fifo;

  localparam int WIDTH    = 64;
  localparam int DEPTH    = 16;
  localparam int AFULL_TH = 14;
  localparam int ADDR_W   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR_W:0]   level;
  logic              almost_full;

  logic [WIDTH-1:0]  exp_q[$];
  int                model_level = 0;
  int                pass_cnt = 0;
  int                check_cnt = 0;

  sync_lane_fifo #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .AFULL_TH(AFULL_TH),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // One clock cycle: drive inputs, check registered outputs against the model, advance model.
  task automatic applyStimulus(input logic iv, input logic [63:0] id, input logic ordy,
                               input logic c, input logic r);
    logic push, pop;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    clr       = c;
    rst       = r;
    #1;
    push = iv && (model_level < DEPTH);
    pop  = out_valid && ordy;
    if (!r) begin
      checkOutput("level", 64'(level), 64'(model_level));
      checkOutput("in_ready", 64'(in_ready), 64'(model_level < DEPTH));
      checkOutput("almost_full", 64'(almost_full), 64'(model_level >= AFULL_TH));
      if (pop && !c) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          checkOutput("out_data", out_data, exp_q[0]);
        end
      end
    end
    @(posedge clk);
    if (r || c) begin
      exp_q.delete();
      model_level = 0;
    end else begin
      if (pop && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        model_level--;
      end
      if (push) begin
        exp_q.push_back(id);
        model_level++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 64) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput("drain_left", 64'(exp_q.size()), 64'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_almost_full", 64'(almost_full), 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);

    $display("[TB] latency");
    applyStimulus(1'b1, 64'hA5, 1'b0, 1'b0, 1'b0);
    checkOutput("lat_n_valid", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("lat_n1_valid", 64'(out_valid), 64'd1);
    checkOutput("lat_n1_data", out_data, 64'hA5);
    drain();

    $display("[TB] fill and drain");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("full_level", 64'(level), 64'd16);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    checkOutput("full_almost_full", 64'(almost_full), 64'd1);
    applyStimulus(1'b1, 64'hBAD, 1'b0, 1'b0, 1'b0);
    checkOutput("full_ignored_level", 64'(level), 64'd16);
    checkOutput("full_head_stable", out_data, 64'h0);
    drain();

    $display("[TB] full contention");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 64'hDEAD, 1'b1, 1'b0, 1'b0);
    checkOutput("contend_level", 64'(level), 64'd15);
    drain();

    $display("[TB] streaming");
    applyStimulus(1'b1, 64'h1000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1'b1, 64'h1000 + 64'(i), 1'b1, 1'b0, 1'b0);
      checkOutput("stream_level", 64'(level), 64'd1);
      checkOutput("stream_valid", 64'(out_valid), 64'd1);
    end
    drain();

    $display("[TB] flush");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 64'h200 + 64'(i), 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_pre_level", 64'(level), 64'd5);
    applyStimulus(1'b1, 64'h999, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_level", 64'(level), 64'd0);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 64'h77, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_first_word", out_data, 64'h77);
    drain();

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 64'h300 + 64'(i), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("rstmid_pre_level", 64'(level), 64'd9);
    applyStimulus(1'b1, 64'h3FF, 1'b1, 1'b0, 1'b1);
    checkOutput("rstmid_level", 64'(level), 64'd0);
    checkOutput("rstmid_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rstmid_out_data", out_data, 64'd0);
    checkOutput("rstmid_almost_full", 64'(almost_full), 64'd0);
    applyStimulus(1'b1, 64'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmid_next_word", out_data, 64'h55);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/sync_lane_fifo.md
SYNC_LANE_FIFO -- requirements
Module: sync_lane_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data word width in bits (one Keccak lane).
REQ-002 SHALL have parameter DEPTH, default 16, total word capacity; must be a power of two and at least 2.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, the level at or above which almost_full asserts; legal range 1..DEPTH.
REQ-004 SHALL have derived parameter ADDR_W, default $clog2(DEPTH), storage address width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port clr  input  1  synchronous flush of contents; same effect as rst on state.
REQ-008 SHALL have port in_valid  input  1  writer presents in_data.
REQ-009 SHALL have port in_ready  output  1  FIFO can accept a word this cycle.
REQ-010 SHALL have port in_data  input  WIDTH  write data.
REQ-011 SHALL have port out_valid  output  1  out_data holds the oldest stored word.
REQ-012 SHALL have port out_ready  input  1  reader consumes out_data this cycle.
REQ-013 SHALL have port out_data  output  WIDTH  head-of-queue word, registered.
REQ-014 SHALL have port level  output  ADDR_W+1  number of stored words, 0..DEPTH.
REQ-015 SHALL have port almost_full  output  1  level >= AFULL_TH.

Function
REQ-016 Push SHALL occur on a rising edge where in_valid && in_ready; pop SHALL occur where out_valid && out_ready.
REQ-017 in_ready SHALL equal (level < DEPTH), combinationally from registered state only; it SHALL NOT depend on out_ready (no pass-through when full).
REQ-018 Output SHALL be first-word-fall-through: out_valid=1 whenever the head word is loaded in the output register; no read request needed.
REQ-019 A word pushed at edge N into an empty FIFO SHALL appear with out_valid=1 after edge N+1 (two-cycle write-to-visible latency); subsequent words SHALL present back-to-back on consecutive pops.
REQ-020 Sustained simultaneous push and pop SHALL give throughput of one word per cycle with level unchanged.
REQ-021 level SHALL increment on push-only, decrement on pop-only, hold on both or neither; it counts words in storage plus the output register, including words not yet visible per REQ-019.
REQ-022 Words SHALL leave in exact push order; no word SHALL be duplicated or dropped, including across storage pointer wrap-around at DEPTH.
REQ-023 out_data SHALL hold its value while out_valid && !out_ready (stable under backpressure).
REQ-024 When out_valid=0, out_data SHALL hold its last value; out_ready SHALL then be ignored.
REQ-025 in_valid while in_ready=0 SHALL be ignored with no state change.
REQ-026 clr SHALL take priority over push and pop in the same cycle: after the edge, level=0, out_valid=0, pointers zero; the word offered that cycle is discarded.
REQ-027 almost_full SHALL be registered-state derived and update in the cycle level changes.

Reset
REQ-028 On rst=1 at a rising edge: level=0, out_valid=0, in_ready=1 (after edge), almost_full=0 (unless AFULL_TH is 0, which is illegal), read/write pointers=0, out_data=0.
REQ-029 Storage array contents SHALL NOT be reset; reset mid-transfer SHALL drop all queued words and behave as empty next cycle.
REQ-030 rst SHALL take priority over clr and all handshakes.

Structure
REQ-031 Storage SHALL be a separate sub-module sync_lane_fifo_ram: simple dual-port, one synchronous write port, one synchronous read port with read-enable, registered read data, no reset on the array.
REQ-032 Control (pointers, level, output-register load) SHALL be in sync_lane_fifo; no state machine beyond pointers, level and the out_valid flag.
REQ-033 Shared package sha3_pkg SHALL hold LANE_W=64 and the default FIFO depth constant; no typedefs are required.

Verification
REQ-034 Fill/drain: DEPTH=16, push 0x0..0xF with out_ready=0 -> in_ready=0 and level=16 after 16th push, almost_full=1 from level 14; then out_ready=1 -> 0x0..0xF out in order, level 0, out_valid=0.
REQ-035 Latency: push 0xA5 at edge N into empty FIFO -> out_valid=0 after N, out_valid=1 and out_data=0xA5 after N+1.
REQ-036 Streaming: push and pop every cycle for 40 words (crosses wrap twice) -> level constant at 1 after warm-up, output sequence equals input sequence.
REQ-037 Full contention: level=16, in_valid=1 and out_ready=1 same cycle -> pop only, level=15, the offered word not stored.
REQ-038 Flush: level=5, assert clr with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, in_ready=1; a following push of 0x77 emerges as first word.
REQ-039 Reset mid-operation: level=9, rst=1 for one edge -> level=0, out_valid=0, out_data=0, almost_full=0; prior words never reappear.
